// File: rtl/hazard3_ahb_rr_arbiter.sv
// hazard3_ahb_rr_arbiter: round-robin share of one AHB5 manager port between N_PORTS requesters
module hazard3_ahb_rr_arbiter #(
    parameter int N_PORTS = 3,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         req_aph,
    input  logic [N_PORTS*W_ADDR-1:0]  req_haddr,
    input  logic [N_PORTS-1:0]         req_hwrite,
    input  logic [N_PORTS*3-1:0]       req_hsize,
    input  logic [N_PORTS*W_DATA-1:0]  req_hwdata,
    output logic [N_PORTS-1:0]         req_aph_rdy,
    output logic [N_PORTS-1:0]         req_dph_rdy,
    output logic [N_PORTS-1:0]         req_dph_err,
    output logic [W_DATA-1:0]          req_hrdata,
    output logic [W_ADDR-1:0]          haddr,
    output logic                       hwrite,
    output logic [2:0]                 hsize,
    output logic [1:0]                 htrans,
    output logic [7:0]                 hmaster,
    output logic [W_DATA-1:0]          hwdata,
    input  logic                       hready,
    input  logic                       hresp,
    input  logic [W_DATA-1:0]          hrdata
);
    localparam int IW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    logic          hold_q, hold_d, dph_vld_q, dph_vld_d;
    logic [IW-1:0] gnt_prev_q, gnt_prev_d, rr_ptr_q, rr_ptr_d, dph_idx_q, dph_idx_d;
    logic          found, gnt_any;
    logic [IW-1:0] cand, srch_idx, gnt_idx;
    logic [N_PORTS-1:0] gnt_oh, dph_oh;
    always_comb begin
        found = 1'b0;
        srch_idx = '0;
        cand = '0;
        // Walk from farthest to nearest so the nearest requester after rr_ptr wins
        for (int k = N_PORTS; k >= 1; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % N_PORTS);
            if (req_aph[cand]) begin
                found = 1'b1;
                srch_idx = cand;
            end
        end
        gnt_any = hold_q | found;
        gnt_idx = hold_q ? gnt_prev_q : srch_idx;
        gnt_oh = N_PORTS'(1) << gnt_idx;
        dph_oh = N_PORTS'(1) << dph_idx_q;
        htrans = gnt_any ? HTRANS_NSEQ : HTRANS_IDLE;
        haddr = gnt_any ? req_haddr[gnt_idx*W_ADDR +: W_ADDR] : '0;
        hwrite = gnt_any & req_hwrite[gnt_idx];
        hsize = gnt_any ? req_hsize[gnt_idx*3 +: 3] : '0;
        hmaster = gnt_any ? 8'(gnt_idx) : '0;
        hwdata = req_hwdata[dph_idx_q*W_DATA +: W_DATA];
        req_hrdata = hrdata;
        req_aph_rdy = (gnt_any && hready) ? gnt_oh : '0;
        req_dph_rdy = (dph_vld_q && hready) ? dph_oh : '0;
        req_dph_err = (dph_vld_q && hresp) ? dph_oh : '0;
        // An error response releases the hold so requesters may withdraw
        hold_d = gnt_any && !hready && !hresp;
        gnt_prev_d = gnt_idx;
        rr_ptr_d = (gnt_any && hready) ? gnt_idx : rr_ptr_q;
        dph_vld_d = hready ? gnt_any : dph_vld_q;
        dph_idx_d = hready ? gnt_idx : dph_idx_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            gnt_prev_q <= '0;
            rr_ptr_q <= IW'(N_PORTS - 1);
            dph_vld_q <= 1'b0;
            dph_idx_q <= '0;
        end else begin
            hold_q <= hold_d;
            gnt_prev_q <= gnt_prev_d;
            rr_ptr_q <= rr_ptr_d;
            dph_vld_q <= dph_vld_d;
            dph_idx_q <= dph_idx_d;
        end
    end
endmodule

// File: tb/tb_hazard3_ahb_rr_arbiter.sv
// tb_hazard3_ahb_rr_arbiter: directed scoreboard bench for the round-robin AHB arbiter
module tb_hazard3_ahb_rr_arbiter;
    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } aph_t;
    typedef struct {
        int          port;
        logic [31:0] wdata;
        logic        write;
        logic        err;
    } dph_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_aph;
    logic [31:0] addr_a [3];
    logic [31:0] wdat_a [3];
    logic [95:0] req_haddr, req_hwdata;
    logic [2:0]  req_hwrite = 3'b101;
    logic [8:0]  req_hsize = {3'd0, 3'd1, 3'd2};
    logic [2:0]  req_aph_rdy, req_dph_rdy, req_dph_err;
    logic [31:0] req_hrdata, haddr, hwdata, hrdata;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [7:0]  hmaster;
    int          n_checks = 0;
    int          n_fail = 0;
    aph_t        aph_q [$];
    dph_t        dph_q [$];
    logic [31:0] v;
    assign req_haddr = {addr_a[2], addr_a[1], addr_a[0]};
    assign req_hwdata = {wdat_a[2], wdat_a[1], wdat_a[0]};
    always #5 clk = ~clk;
    hazard3_ahb_rr_arbiter #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_aph(req_aph), .req_haddr(req_haddr),
        .req_hwrite(req_hwrite), .req_hsize(req_hsize), .req_hwdata(req_hwdata),
        .req_aph_rdy(req_aph_rdy), .req_dph_rdy(req_dph_rdy), .req_dph_err(req_dph_err),
        .req_hrdata(req_hrdata), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hmaster(hmaster), .hwdata(hwdata), .hready(hready),
        .hresp(hresp), .hrdata(hrdata)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic exp_aph(input int p);
        aph_q.push_back('{p, addr_a[p], req_hwrite[p], 3'(2 - p)});
    endtask
    task automatic exp_xfer(input int p, input logic err = 1'b0);
        exp_aph(p);
        dph_q.push_back('{p, wdat_a[p], req_hwrite[p], err});
    endtask
    task automatic sample();
        aph_t a;
        dph_t d;
        if (|req_aph_rdy) begin
            if (aph_q.size() == 0) chk("aph_unexpected", 64'(req_aph_rdy), 64'd0);
            else begin
                a = aph_q.pop_front();
                chk("aph_rdy", 64'(req_aph_rdy), 64'd1 << a.port);
                chk("aph_htrans", 64'(htrans), 64'd2);
                chk("aph_hmaster", 64'(hmaster), 64'(a.port));
                chk("aph_haddr", 64'(haddr), 64'(a.addr));
                chk("aph_hwrite", 64'(hwrite), 64'(a.write));
                chk("aph_hsize", 64'(hsize), 64'(a.size));
            end
        end
        if (|req_dph_rdy) begin
            if (dph_q.size() == 0) chk("dph_unexpected", 64'(req_dph_rdy), 64'd0);
            else begin
                d = dph_q.pop_front();
                chk("dph_rdy", 64'(req_dph_rdy), 64'd1 << d.port);
                chk("dph_err", 64'(req_dph_err), d.err ? 64'd1 << d.port : 64'd0);
                if (d.write) chk("dph_hwdata", 64'(hwdata), 64'(d.wdata));
            end
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        req_aph = '0;
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = '0;
        for (int i = 0; i < 3; i++) begin
            addr_a[i] = 32'h1000_0000 + 32'(i) * 32'h100;
            wdat_a[i] = 32'hA000_0000 + 32'(i);
        end
        repeat (2) cyc();
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_hmaster", 64'(hmaster), 64'd0);
        chk("rst_rdy", 64'({req_aph_rdy, req_dph_rdy, req_dph_err}), 64'd0);
        rst_n = 1'b1;
        // all ports requesting: strict rotation starting at port 0
        req_aph = 3'b111;
        for (int i = 0; i < 6; i++) exp_xfer(i % 3);
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr_hmaster", 64'(hmaster), 64'(i % 3));
            cyc();
        end
        req_aph = '0;
        cyc();
        // stalled port 1 address phase stays put while port 0 asks
        req_aph = 3'b010;
        hready = 1'b0;
        exp_xfer(1);
        exp_xfer(0);
        #1 chk("stall_first_aph_rdy", 64'(req_aph_rdy), 64'd0);
        cyc();
        req_aph = 3'b011;
        for (int i = 0; i < 2; i++) begin
            #1 chk("stall_hmaster", 64'(hmaster), 64'd1);
            chk("stall_haddr", 64'(haddr), 64'(addr_a[1]));
            cyc();
        end
        hready = 1'b1;
        #1 chk("stall_release", 64'(req_aph_rdy), 64'b010);
        cyc();
        req_aph = 3'b001;
        cyc();
        req_aph = '0;
        cyc();
        // port 2 write data phase overlaps port 0 address phase
        addr_a[2] = 32'h2000_0000;
        wdat_a[2] = 32'hDEAD_BEEF;
        req_aph = 3'b100;
        exp_xfer(2);
        exp_xfer(0);
        #1 chk("wr_hmaster", 64'(hmaster), 64'd2);
        cyc();
        req_aph = 3'b001;
        #1 chk("wr_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
        chk("wr_dph_rdy", 64'(req_dph_rdy), 64'b100);
        chk("wr_next_hmaster", 64'(hmaster), 64'd0);
        cyc();
        req_aph = '0;
        cyc();
        // two-cycle error response on port 1 data phase
        req_aph = 3'b010;
        exp_xfer(1, 1'b1);
        cyc();
        req_aph = 3'b100;
        hresp = 1'b1;
        hready = 1'b0;
        #1 chk("err1_err", 64'(req_dph_err), 64'b010);
        chk("err1_rdy", 64'(req_dph_rdy), 64'd0);
        chk("err1_hmaster", 64'(hmaster), 64'd2);
        cyc();
        req_aph = '0;
        hready = 1'b1;
        #1 chk("err2_err", 64'(req_dph_err), 64'b010);
        chk("err2_rdy", 64'(req_dph_rdy), 64'b010);
        chk("err2_hold_clear", 64'(htrans), 64'd0);
        cyc();
        hresp = 1'b0;
        #1 chk("err_done", 64'({req_dph_rdy, req_dph_err}), 64'd0);
        cyc();
        // single requester: back-to-back grants, no idle bubbles
        req_aph = 3'b001;
        for (int i = 0; i < 5; i++) exp_xfer(0);
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            hrdata = v;
            #1 chk("solo_htrans", 64'(htrans), 64'd2);
            chk("solo_hmaster", 64'(hmaster), 64'd0);
            chk("solo_hrdata", 64'(req_hrdata), 64'(v));
            cyc();
        end
        req_aph = '0;
        cyc();
        // reset mid-transfer drops the in-flight data phase
        req_aph = 3'b010;
        exp_aph(1);
        cyc();
        rst_n = 1'b0;
        req_aph = '0;
        hready = 1'b0;
        cyc();
        rst_n = 1'b1;
        hready = 1'b1;
        #1 chk("rst_mid_dph_rdy", 64'(req_dph_rdy), 64'd0);
        req_aph = 3'b111;
        exp_xfer(0);
        #1 chk("rst_mid_first_gnt", 64'(hmaster), 64'd0);
        cyc();
        req_aph = '0;
        for (int i = 0; i < 10 && dph_q.size() > 0; i++) cyc();
        chk("aph_q_drained", 64'(aph_q.size()), 64'd0);
        chk("dph_q_drained", 64'(dph_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
